player_shot_pool: RTL

//   Fixed pool of player shots for the STG playfield. Spawns a shot at the player
//   on `fire`, moves live shots upward once per game tick, retires them at the top

---
 rtl/player_shot_pool.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/player_shot_pool.sv
// rtl/player_shot_pool.sv - fixed pool of player shots: spawn, per-tick sweep, boss collision, render
module player_shot_pool #(
    parameter int          NUM_SHOTS   = 8,
    parameter int          TICK_DIV    = 4000000,
    parameter int          SHOT_SPEED  = 4,
    parameter int          COOLDOWN    = 6,
    parameter int          SHOT_W      = 4,
    parameter int          SHOT_H      = 12,
    parameter int          BOSS_HALF_W = 32,
    parameter int          BOSS_HALF_H = 48,
    parameter logic [11:0] SHOT_COLOR  = 12'hF0F
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fire,
    input  logic [9:0]  player_x,
    input  logic [9:0]  player_y,
    input  logic [9:0]  boss_x,
    input  logic [9:0]  boss_y,
    input  logic        boss_alive,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    output logic        is_hit,
    output logic [3:0]  hit_count,
    output logic [4:0]  active_count,
    output logic        shot_on,
    output logic [11:0] rgb_out
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int IW = $clog2(NUM_SHOTS);
    localparam int CW = $clog2(COOLDOWN + 2);

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [IW-1:0] LAST_SLOT = IW'(NUM_SHOTS - 1);
    localparam logic [CW-1:0] CD_INIT   = CW'(COOLDOWN);
    localparam logic [10:0]   HSW       = 11'(SHOT_W / 2);
    localparam logic [10:0]   HSH       = 11'(SHOT_H / 2);
    localparam logic [10:0]   BHW       = 11'(BOSS_HALF_W);
    localparam logic [10:0]   BHH       = 11'(BOSS_HALF_H);
    localparam logic [10:0]   TOP_LIMIT = 11'(SHOT_SPEED + SHOT_H / 2);
    localparam logic [9:0]    SPEED     = 10'(SHOT_SPEED);
    localparam logic [9:0]    SPAWN_OFS = 10'd16;

    typedef enum logic [1:0] {
        IDLE,
        UPDATE,
        SPAWN
    } state_t;

    state_t state, state_next;

    logic [TW-1:0]        tick_cnt;
    logic                 tick;
    logic [IW-1:0]        idx;
    logic [3:0]           hits;
    logic [CW-1:0]        cooldown;
    logic [NUM_SHOTS-1:0] valid;
    logic [9:0]           pos_x [NUM_SHOTS];
    logic [9:0]           pos_y [NUM_SHOTS];

    logic                 start_sweep, do_update, do_spawn;

    // Tick strobe generator
    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (tick) state_next = UPDATE;
            UPDATE:  if (idx == LAST_SLOT) state_next = SPAWN;
            SPAWN:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        start_sweep = 1'b0;
        do_update   = 1'b0;
        do_spawn    = 1'b0;
        case (state)
            IDLE:    start_sweep = tick;
            UPDATE:  do_update   = 1'b1;
            SPAWN:   do_spawn    = 1'b1;
            default: ;
        endcase
    end

    // Slot under update; overlap is rearranged into sums so nothing underflows
    logic [10:0] cur_x, cur_y, bx, by;
    logic        off_top, overlap;
    logic [3:0]  hits_inc;

    assign cur_x    = {1'b0, pos_x[idx]};
    assign cur_y    = {1'b0, pos_y[idx]};
    assign bx       = {1'b0, boss_x};
    assign by       = {1'b0, boss_y};
    assign off_top  = (cur_y < TOP_LIMIT);
    assign overlap  = boss_alive
                   && (cur_x < bx + BHW + HSW) && (bx < cur_x + HSW + BHW)
                   && (cur_y < by + BHH + HSH) && (by < cur_y + HSH + BHH);
    assign hits_inc = (hits == 4'hF) ? 4'hF : hits + 4'd1;

    logic [CW-1:0] cd_dec;
    logic [9:0]    spawn_y;
    logic          free_found;
    logic [IW-1:0] free_idx;

    assign cd_dec  = (cooldown == '0) ? '0 : cooldown - CW'(1);
    assign spawn_y = (player_y < SPAWN_OFS) ? 10'd0 : player_y - SPAWN_OFS;

    // Descending scan so the lowest free index wins
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NUM_SHOTS - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid     <= '0;
            idx       <= '0;
            hits      <= '0;
            cooldown  <= '0;
            is_hit    <= 1'b0;
            hit_count <= '0;
            for (int i = 0; i < NUM_SHOTS; i++) begin
                pos_x[i] <= '0;
                pos_y[i] <= '0;
            end
        end else begin
            if (start_sweep) begin
                idx  <= '0;
                hits <= '0;
            end
            if (do_update) begin
                if (valid[idx]) begin
                    if (off_top) begin
                        valid[idx] <= 1'b0;
                    end else if (overlap) begin
                        valid[idx] <= 1'b0;
                        hits       <= hits_inc;
                    end else begin
                        pos_y[idx] <= pos_y[idx] - SPEED;
                    end
                end
                idx <= idx + IW'(1);
            end
            if (do_spawn) begin
                cooldown <= cd_dec;
                if (fire && (cd_dec == '0) && free_found) begin
                    valid[free_idx] <= 1'b1;
                    pos_x[free_idx] <= player_x;
                    pos_y[free_idx] <= spawn_y;
                    cooldown        <= CD_INIT;
                end
                hit_count <= hits;
                is_hit    <= (hits != 4'd0);
            end
        end
    end

    always_comb begin
        active_count = '0;
        for (int i = 0; i < NUM_SHOTS; i++) begin
            active_count = active_count + 5'(valid[i]);
        end
    end

    logic [10:0] px, py;
    assign px = {1'b0, x};
    assign py = {1'b0, y};

    always_comb begin
        shot_on = 1'b0;
        for (int i = 0; i < NUM_SHOTS; i++) begin
            if (valid[i]
                && (px + HSW >= {1'b0, pos_x[i]}) && (px < {1'b0, pos_x[i]} + HSW)
                && (py + HSH >= {1'b0, pos_y[i]}) && (py < {1'b0, pos_y[i]} + HSH)) begin
                shot_on = 1'b1;
            end
        end
    end

    assign rgb_out = shot_on ? SHOT_COLOR : 12'h000;

endmodule
